// File: rtl/memory_arbiter.sv
// memory_arbiter: shares the single main-memory port between the instruction
// cache (port I) and the data cache (port D). One client owns the memory at a
// time; the owner's signals are forwarded combinationally and the other client
// sees the memory as busy.
// Optional feature macro: ARBITER_ROUND_ROBIN_EN. When it is defined, a
// last_grant register gives alternating priority on simultaneous requests.
// When it is undefined, arbitration uses fixed priority with D over I.
module memory_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  // port I (instruction cache)
  input  logic                  i_mem_enable,
  input  logic                  i_mem_op_init,
  input  logic                  i_mem_op,
  input  logic [ADDR_WIDTH-1:0] i_mem_address,
  input  logic [LINE_WIDTH-1:0] i_mem_data_in,
  input  logic                  i_mem_op_done,
  output logic [LINE_WIDTH-1:0] i_mem_data_out,
  output logic                  i_mem_data_ready,
  output logic                  i_memory_in_use,
  // port D (data cache)
  input  logic                  d_mem_enable,
  input  logic                  d_mem_op_init,
  input  logic                  d_mem_op,
  input  logic [ADDR_WIDTH-1:0] d_mem_address,
  input  logic [LINE_WIDTH-1:0] d_mem_data_in,
  input  logic                  d_mem_op_done,
  output logic [LINE_WIDTH-1:0] d_mem_data_out,
  output logic                  d_mem_data_ready,
  output logic                  d_memory_in_use,
  // memory side
  output logic                  mem_enable,
  output logic                  mem_op_init,
  output logic                  mem_op,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_data_in,
  output logic                  mem_op_done,
  input  logic [LINE_WIDTH-1:0] mem_data_out,
  input  logic                  mem_data_ready,
  input  logic                  mem_memory_in_use
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   req_i, req_d, prefer_d;

  assign req_i = i_mem_enable & i_mem_op_init;
  assign req_d = d_mem_enable & d_mem_op_init;

`ifdef ARBITER_ROUND_ROBIN_EN
  // last_grant encoding: 0 = port I, 1 = port D
  logic last_grant_q, last_grant_d;

  assign prefer_d = ~last_grant_q;

  // Record which port received the most recent grant out of IDLE
  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && state_d == BUSY_I) last_grant_d = 1'b0;
    else if (state_q == IDLE && state_d == BUSY_D) last_grant_d = 1'b1;
  end
`else
  assign prefer_d = 1'b1;
`endif

  // Next grant: arbitrate only from IDLE; the owner leaves on op_done or when it drops enable
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_i && req_d) state_d = prefer_d ? BUSY_D : BUSY_I;
        else if (req_d)     state_d = BUSY_D;
        else if (req_i)     state_d = BUSY_I;
      end
      BUSY_I: if (i_mem_op_done || !i_mem_enable) state_d = IDLE;
      BUSY_D: if (d_mem_op_done || !d_mem_enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant register; reset returns to IDLE from any state, even mid-transfer
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
`ifdef ARBITER_ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef ARBITER_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Route the owner's signals to memory and mark the memory busy for the other port
  always_comb begin
    mem_enable       = 1'b0;
    mem_op_init      = 1'b0;
    mem_op           = 1'b0;
    mem_address      = '0;
    mem_data_in      = '0;
    mem_op_done      = 1'b0;
    i_mem_data_out   = '0;
    i_mem_data_ready = 1'b0;
    i_memory_in_use  = mem_memory_in_use;
    d_mem_data_out   = '0;
    d_mem_data_ready = 1'b0;
    d_memory_in_use  = mem_memory_in_use;
    case (state_q)
      BUSY_I: begin
        mem_enable       = i_mem_enable;
        mem_op_init      = i_mem_op_init;
        mem_op           = i_mem_op;
        mem_address      = i_mem_address;
        mem_data_in      = i_mem_data_in;
        mem_op_done      = i_mem_op_done;
        i_mem_data_out   = mem_data_out;
        i_mem_data_ready = mem_data_ready;
        d_memory_in_use  = 1'b1;
      end
      BUSY_D: begin
        mem_enable       = d_mem_enable;
        mem_op_init      = d_mem_op_init;
        mem_op           = d_mem_op;
        mem_address      = d_mem_address;
        mem_data_in      = d_mem_data_in;
        mem_op_done      = d_mem_op_done;
        d_mem_data_out   = mem_data_out;
        d_mem_data_ready = mem_data_ready;
        i_memory_in_use  = 1'b1;
      end
      default: ;
    endcase
    // Neither client may start while reset is held
    if (!reset) begin
      i_memory_in_use = 1'b1;
      d_memory_in_use = 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: vector table, directed multi-cycle sequences and a
// randomized run compared against a transaction-level ownership model.
module tb_memory_arbiter;
  localparam int AW = 12;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_mem_enable, i_mem_op_init, i_mem_op, i_mem_op_done;
  logic [AW-1:0] i_mem_address;
  logic [LW-1:0] i_mem_data_in, i_mem_data_out;
  logic          i_mem_data_ready, i_memory_in_use;
  logic          d_mem_enable, d_mem_op_init, d_mem_op, d_mem_op_done;
  logic [AW-1:0] d_mem_address;
  logic [LW-1:0] d_mem_data_in, d_mem_data_out;
  logic          d_mem_data_ready, d_memory_in_use;
  logic          mem_enable, mem_op_init, mem_op, mem_op_done;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_data_in, mem_data_out;
  logic          mem_data_ready, mem_memory_in_use;

  memory_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .reset(reset),
    .i_mem_enable(i_mem_enable), .i_mem_op_init(i_mem_op_init), .i_mem_op(i_mem_op),
    .i_mem_address(i_mem_address), .i_mem_data_in(i_mem_data_in), .i_mem_op_done(i_mem_op_done),
    .i_mem_data_out(i_mem_data_out), .i_mem_data_ready(i_mem_data_ready), .i_memory_in_use(i_memory_in_use),
    .d_mem_enable(d_mem_enable), .d_mem_op_init(d_mem_op_init), .d_mem_op(d_mem_op),
    .d_mem_address(d_mem_address), .d_mem_data_in(d_mem_data_in), .d_mem_op_done(d_mem_op_done),
    .d_mem_data_out(d_mem_data_out), .d_mem_data_ready(d_mem_data_ready), .d_memory_in_use(d_memory_in_use),
    .mem_enable(mem_enable), .mem_op_init(mem_op_init), .mem_op(mem_op),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_op_done(mem_op_done),
    .mem_data_out(mem_data_out), .mem_data_ready(mem_data_ready), .mem_memory_in_use(mem_memory_in_use)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: who owns memory (0 = nobody, 1 = I, 2 = D)
  int m_owner = 0;
`ifdef ARBITER_ROUND_ROBIN_EN
  int m_last = 1;
`endif

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Ownership changes only at the clock edge, based on the inputs of the ending cycle
  task automatic model_next();
    bit ri, rd;
    ri = i_mem_enable && i_mem_op_init;
    rd = d_mem_enable && d_mem_op_init;
    if (!reset) begin
      m_owner = 0;
`ifdef ARBITER_ROUND_ROBIN_EN
      m_last = 1;
`endif
    end else if (m_owner == 0) begin
      if (ri && rd) begin
`ifdef ARBITER_ROUND_ROBIN_EN
        m_owner = (m_last == 2) ? 1 : 2;
`else
        m_owner = 2;
`endif
      end else if (rd) m_owner = 2;
      else if (ri) m_owner = 1;
`ifdef ARBITER_ROUND_ROBIN_EN
      if (m_owner != 0) m_last = m_owner;
`endif
    end else if (m_owner == 1) begin
      if (i_mem_op_done || !i_mem_enable) m_owner = 0;
    end else begin
      if (d_mem_op_done || !d_mem_enable) m_owner = 0;
    end
  endtask

  task automatic adv();
    model_next();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs: owner's request reaches memory, owner sees memory results, other port sees busy
  task automatic check_model(input int cyc);
    logic [AW+4:0] e_bus;
    logic [LW-1:0] e_din, e_iout, e_dout;
    logic e_irdy, e_drdy, e_iuse, e_duse;
    e_bus = '0; e_din = '0; e_iout = '0; e_dout = '0;
    e_irdy = 1'b0; e_drdy = 1'b0;
    e_iuse = mem_memory_in_use; e_duse = mem_memory_in_use;
    if (m_owner == 1) begin
      e_bus  = {i_mem_enable, i_mem_op_init, i_mem_op, i_mem_address, i_mem_op_done};
      e_din  = i_mem_data_in;
      e_iout = mem_data_out;
      e_irdy = mem_data_ready;
      e_duse = 1'b1;
    end else if (m_owner == 2) begin
      e_bus  = {d_mem_enable, d_mem_op_init, d_mem_op, d_mem_address, d_mem_op_done};
      e_din  = d_mem_data_in;
      e_dout = mem_data_out;
      e_drdy = mem_data_ready;
      e_iuse = 1'b1;
    end
    if (!reset) begin
      e_iuse = 1'b1;
      e_duse = 1'b1;
    end
    chk($sformatf("rnd%0d_bus", cyc), {mem_enable, mem_op_init, mem_op, mem_address, mem_op_done}, e_bus);
    chk($sformatf("rnd%0d_din", cyc), mem_data_in, e_din);
    chk($sformatf("rnd%0d_iout", cyc), i_mem_data_out, e_iout);
    chk($sformatf("rnd%0d_dout", cyc), d_mem_data_out, e_dout);
    chk($sformatf("rnd%0d_flags", cyc), {i_mem_data_ready, i_memory_in_use, d_mem_data_ready, d_memory_in_use},
        {e_irdy, e_iuse, e_drdy, e_duse});
  endtask

  task automatic clear_ins();
    i_mem_enable = 0; i_mem_op_init = 0; i_mem_op = 0; i_mem_op_done = 0;
    d_mem_enable = 0; d_mem_op_init = 0; d_mem_op = 0; d_mem_op_done = 0;
  endtask

  // inputs:   rst | ie ii iop idn | de di dop ddn | mrdy | mbusy
  // expected: men minit mdone irdy drdy iuse duse, then mem_address
  typedef struct packed {
    logic [10:0]   in;
    logic [6:0]    ex;
    logic [AW-1:0] addr;
  } vec_t;
  vec_t tbl [14];

  initial begin
    bit         win_d;
    logic [AW-1:0] w_addr, l_addr;
    int         pulses;

    tbl[0]  = {11'b0_0000_0000_1_0, 7'b0000011, 12'h000}; // reset held: both busy, no ready
    tbl[1]  = {11'b1_1110_0000_0_0, 7'b0000000, 12'h000}; // I read request in IDLE
    tbl[2]  = {11'b1_1010_0000_0_1, 7'b1000011, 12'h010}; // BUSY_I, memory busy
    tbl[3]  = {11'b1_1010_0000_1_0, 7'b1001001, 12'h010}; // result ready for I
    tbl[4]  = {11'b1_1011_1100_1_0, 7'b1011001, 12'h010}; // I done, D init ignored
    tbl[5]  = {11'b1_0000_1100_0_0, 7'b0000000, 12'h000}; // turnaround IDLE, D pending
    tbl[6]  = {11'b1_1100_1000_0_1, 7'b1000011, 12'h020}; // BUSY_D, I pending
    tbl[7]  = {11'b0_1100_1000_1_0, 7'b1000111, 12'h020}; // reset low mid BUSY_D
    tbl[8]  = {11'b0_1100_1000_1_0, 7'b0000011, 12'h000}; // back in IDLE under reset
    tbl[9]  = {11'b1_1110_0000_0_0, 7'b0000000, 12'h000}; // I request
    tbl[10] = {11'b1_0010_1100_0_0, 7'b0000001, 12'h010}; // I aborts: mem_enable drops now
    tbl[11] = {11'b1_0000_1100_0_0, 7'b0000000, 12'h000}; // IDLE, D pending
    tbl[12] = {11'b1_0000_1001_1_0, 7'b1010110, 12'h020}; // D granted, done
    tbl[13] = {11'b1_0000_0000_0_0, 7'b0000000, 12'h000}; // idle

    reset = 0; clear_ins();
    mem_data_ready = 0; mem_memory_in_use = 0; mem_data_out = {4{32'h5A5A_0F0F}};
    i_mem_address = 12'h010; d_mem_address = 12'h020;
    i_mem_data_in = '0; d_mem_data_in = '0;
    #1;
    adv(); adv();

    // Vector table
    for (int k = 0; k < 14; k++) begin
      {reset, i_mem_enable, i_mem_op_init, i_mem_op, i_mem_op_done,
       d_mem_enable, d_mem_op_init, d_mem_op, d_mem_op_done,
       mem_data_ready, mem_memory_in_use} = tbl[k].in;
      #2;
      chk($sformatf("vec%0d_flags", k),
          {mem_enable, mem_op_init, mem_op_done, i_mem_data_ready, d_mem_data_ready, i_memory_in_use, d_memory_in_use},
          tbl[k].ex);
      chk($sformatf("vec%0d_addr", k), mem_address, tbl[k].addr);
      adv();
    end

    // Simultaneous requests; previous grant went to D
`ifdef ARBITER_ROUND_ROBIN_EN
    win_d = 1'b0;
`else
    win_d = 1'b1;
`endif
    w_addr = win_d ? 12'h020 : 12'h010;
    l_addr = win_d ? 12'h010 : 12'h020;
    reset = 1; clear_ins(); mem_data_ready = 0; mem_memory_in_use = 0;
    i_mem_enable = 1; i_mem_op_init = 1; i_mem_op = 1;
    d_mem_enable = 1; d_mem_op_init = 1; d_mem_op = 1;
    #2; chk("simul_idle_en", mem_enable, 1'b0); adv();
    if (win_d) d_mem_op_done = 1; else i_mem_op_done = 1;
    #2; chk("simul_winner_addr", {mem_enable, mem_address}, {1'b1, w_addr}); adv();
    if (win_d) begin d_mem_enable = 0; d_mem_op_init = 0; d_mem_op_done = 0; end
    else begin i_mem_enable = 0; i_mem_op_init = 0; i_mem_op_done = 0; end
    #2; chk("simul_turnaround_en", mem_enable, 1'b0); adv();
    if (win_d) i_mem_op_done = 1; else d_mem_op_done = 1;
    #2; chk("simul_loser_addr", {mem_enable, mem_address}, {1'b1, l_addr}); adv();
    clear_ins(); #2; adv();

    // D write held off while I owns memory, then delivered unaltered
    i_mem_enable = 1; i_mem_op_init = 1; i_mem_op = 1;
    #2; adv();
    i_mem_op_init = 0;
    d_mem_enable = 1; d_mem_op_init = 1; d_mem_op = 0;
    d_mem_data_in = {32'hCAFE_BABE, 32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF};
    #2; chk("wr_blocked_init", {mem_op_init, mem_address}, {1'b0, 12'h010});
    chk("wr_blocked_din", mem_data_in, i_mem_data_in); adv();
    i_mem_op_done = 1;
    #2; chk("wr_i_release", {mem_op_done, mem_op_init}, 2'b10); adv();
    i_mem_enable = 0; i_mem_op_done = 0;
    #2; chk("wr_turnaround_en", mem_enable, 1'b0); adv();
    d_mem_op_done = 1;
    #2; chk("wr_d_bus", {mem_enable, mem_op_init, mem_op, mem_address}, {3'b110, 12'h020});
    chk("wr_d_data", mem_data_in, {32'hCAFE_BABE, 32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF}); adv();
    clear_ins(); #2; adv();

    // Back-to-back I transfers: grants alternate with one IDLE cycle
    pulses = 0;
    i_mem_enable = 1; i_mem_op_init = 1; i_mem_op = 1; i_mem_op_done = 1;
    for (int k = 0; k < 10; k++) begin
      #2;
      chk($sformatf("b2b%0d_en", k), {mem_enable, mem_op_done}, {2{k[0]}});
      if (mem_op_done) pulses++;
      adv();
    end
    chk("b2b_done_pulses", pulses, 5);
    clear_ins(); #2; adv();

    // Randomized run against the ownership model
    for (int c = 0; c < 600; c++) begin
      reset             = ($urandom_range(0, 39) != 0);
      i_mem_enable      = ($urandom_range(0, 9) < 7);
      i_mem_op_init     = ($urandom_range(0, 1) == 1);
      i_mem_op          = $urandom_range(0, 1);
      i_mem_op_done     = ($urandom_range(0, 3) == 0);
      d_mem_enable      = ($urandom_range(0, 9) < 7);
      d_mem_op_init     = ($urandom_range(0, 1) == 1);
      d_mem_op          = $urandom_range(0, 1);
      d_mem_op_done     = ($urandom_range(0, 3) == 0);
      i_mem_address     = AW'($urandom);
      d_mem_address     = AW'($urandom);
      i_mem_data_in     = {$urandom, $urandom, $urandom, $urandom};
      d_mem_data_in     = {$urandom, $urandom, $urandom, $urandom};
      mem_data_out      = {$urandom, $urandom, $urandom, $urandom};
      mem_data_ready    = $urandom_range(0, 1);
      mem_memory_in_use = $urandom_range(0, 1);
      #2;
      check_model(c);
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
